// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with an up/down walking-one scan engine.
module onehot_scan_decoder #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned OUT_W      = 1 << SEL_W,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] outsig,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    DECODE  = 2'b01,
    SCAN_UP = 2'b10,
    SCAN_DN = 2'b11
  } mode_t;

  // The output vector is sized from the index; any other width is a wiring error.
  if (OUT_W != (1 << SEL_W)) begin : g_bad_width
    $error("onehot_scan_decoder: OUT_W must equal 2**SEL_W");
  end

  mode_t            mode_q;
  logic [DIV_W-1:0] presc;
  logic [SEL_W-1:0] idx_up;
  logic [SEL_W-1:0] idx_dn;
  logic             mode_chg;
  logic             step_due;

  // One-hot (or one-cold) image of an index.
  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // Neighbour indices and step qualification; >= also catches div shrinking below the count.
  always_comb begin
    idx_up   = idx + SEL_W'(1);
    idx_dn   = idx - SEL_W'(1);
    mode_chg = (mode_t'(mode) != mode_q);
    step_due = (presc >= div);
  end

  // Mode register, prescaler, index and the output image that tracks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= HOLD;
      presc  <= '0;
      idx    <= '0;
      outsig <= dec(SEL_W'(0));
      wrap   <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else begin
      mode_q <= mode_t'(mode);
      wrap   <= 1'b0;
      if (mode_chg) begin
        presc <= '0;
      end else begin
        case (mode_q)
          HOLD: begin
            presc <= '0;
          end
          DECODE: begin
            presc <= '0;
            if (sel_valid) begin
              idx    <= sel;
              outsig <= dec(sel);
            end
          end
          SCAN_UP: begin
            if (step_due) begin
              presc  <= '0;
              idx    <= idx_up;
              outsig <= dec(idx_up);
              wrap   <= (idx == {SEL_W{1'b1}});
            end else begin
              presc <= presc + DIV_W'(1);
            end
          end
          SCAN_DN: begin
            if (step_due) begin
              presc  <= '0;
              idx    <= idx_dn;
              outsig <= dec(idx_dn);
              wrap   <= (idx == SEL_W'(0));
            end else begin
              presc <= presc + DIV_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
